// File: rtl/id_ex_operand_stage_pkg.sv
// Shared RV32IM definitions: ALU select codes and the ID/EX bubble control word.
package rv32_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_MUL    = 5'd8;
    localparam logic [4:0] ALU_MULH   = 5'd9;
    localparam logic [4:0] ALU_MULHU  = 5'd10;
    localparam logic [4:0] ALU_MULHSU = 5'd11;
    localparam logic [4:0] ALU_DIV    = 5'd12;
    localparam logic [4:0] ALU_DIVU   = 5'd13;
    localparam logic [4:0] ALU_REM    = 5'd14;
    localparam logic [4:0] ALU_REMU   = 5'd15;
    localparam logic [4:0] ALU_SLT    = 5'd16;
    localparam logic [4:0] ALU_SLTU   = 5'd17;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] rd;
        logic [4:0] alu_sel;
    } ex_ctrl_t;

    // A bubble must never write anything back or touch memory.
    localparam ex_ctrl_t BUBBLE_CTRL = '{
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        rd:        5'd0,
        alu_sel:   ALU_ADD
    };

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, forwarding-side and EX-side signals of the ID/EX operand stage.
interface id_ex_operand_stage_if #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
);
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic [4:0]       id_alu_sel;
    logic             id_alu_src;
    logic             id_pc_src;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic [2:0]       id_funct3;
    logic             flush;
    logic             exmem_reg_write;
    logic [4:0]       exmem_rd;
    logic [XLEN-1:0]  exmem_result;
    logic             memwb_reg_write;
    logic [4:0]       memwb_rd;
    logic [XLEN-1:0]  memwb_result;

    logic             stall;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_data1;
    logic [XLEN-1:0]  ex_data2;
    logic [4:0]       ex_alu_sel;
    logic [XLEN-1:0]  ex_store_data;
    logic [XLEN-1:0]  ex_pc;
    logic [4:0]       ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alu_sel, id_alu_src, id_pc_src, id_reg_write, id_mem_read, id_mem_write,
               id_funct3, flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  stall, ex_valid, ex_data1, ex_data2, ex_alu_sel, ex_store_data, ex_pc, ex_rd,
               ex_funct3, ex_reg_write, ex_mem_read, ex_mem_write, stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alu_sel, id_alu_src, id_pc_src, id_reg_write, id_mem_read, id_mem_write,
               id_funct3, flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output stall, ex_valid, ex_data1, ex_data2, ex_alu_sel, ex_store_data, ex_pc, ex_rd,
               ex_funct3, ex_reg_write, ex_mem_read, ex_mem_write, stall_cnt
    );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB, x0 is never forwarded.
module fwd_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic            exmem_reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] data
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs);
    assign memwb_hit = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs);

    always_comb begin
        if (exmem_hit) begin
            data = exmem_result;
        end else if (memwb_hit) begin
            data = memwb_result;
        end else begin
            data = reg_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall detection and EX/MEM, MEM/WB operand forwarding.
module id_ex_operand_stage
    import rv32_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic CLK,
    input  logic RESETN,
    id_ex_operand_stage_if.slave bus
);

    logic                   ex_valid;
    logic [XLEN-1:0]        ex_pc;
    logic [XLEN-1:0]        ex_rs1_data;
    logic [XLEN-1:0]        ex_rs2_data;
    logic [XLEN-1:0]        ex_imm;
    logic [4:0]             ex_rs1;
    logic [4:0]             ex_rs2;
    logic                   ex_alu_src;
    logic                   ex_pc_src;
    logic [2:0]             ex_funct3;
    ex_ctrl_t               ex_ctrl;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   stall;
    logic                   load_bubble;
    logic [XLEN-1:0]        rs1_fwd;
    logic [XLEN-1:0]        rs2_fwd;

    // rs2 is compared even for instructions that ignore it; one spare stall is cheaper than decoding usage.
    assign stall = bus.id_valid && ex_valid && ex_ctrl.mem_read && (ex_ctrl.rd != 5'd0)
                && ((ex_ctrl.rd == bus.id_rs1) || (ex_ctrl.rd == bus.id_rs2)) && !bus.flush;

    assign load_bubble = bus.flush || stall || !bus.id_valid;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_alu_src  <= 1'b0;
            ex_pc_src   <= 1'b0;
            ex_funct3   <= 3'd0;
            ex_ctrl     <= '0;
        end else if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_alu_src  <= 1'b0;
            ex_pc_src   <= 1'b0;
            ex_funct3   <= 3'd0;
            ex_ctrl     <= BUBBLE_CTRL;
        end else begin
            ex_valid          <= 1'b1;
            ex_pc             <= bus.id_pc;
            ex_rs1_data       <= bus.id_rs1_data;
            ex_rs2_data       <= bus.id_rs2_data;
            ex_imm            <= bus.id_imm;
            ex_rs1            <= bus.id_rs1;
            ex_rs2            <= bus.id_rs2;
            ex_alu_src        <= bus.id_alu_src;
            ex_pc_src         <= bus.id_pc_src;
            ex_funct3         <= bus.id_funct3;
            ex_ctrl.reg_write <= bus.id_reg_write;
            ex_ctrl.mem_read  <= bus.id_mem_read;
            ex_ctrl.mem_write <= bus.id_mem_write;
            ex_ctrl.rd        <= bus.id_rd;
            ex_ctrl.alu_sel   <= bus.id_alu_sel;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs              (ex_rs1),
        .reg_data        (ex_rs1_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .data            (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs              (ex_rs2),
        .reg_data        (ex_rs2_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .data            (rs2_fwd)
    );

    assign bus.stall         = stall;
    assign bus.ex_valid      = ex_valid;
    assign bus.ex_data1      = ex_pc_src  ? ex_pc  : rs1_fwd;
    assign bus.ex_data2      = ex_alu_src ? ex_imm : rs2_fwd;
    assign bus.ex_store_data = rs2_fwd;
    assign bus.ex_alu_sel    = ex_ctrl.alu_sel;
    assign bus.ex_pc         = ex_pc;
    assign bus.ex_rd         = ex_ctrl.rd;
    assign bus.ex_funct3     = ex_funct3;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.stall_cnt     = stall_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: forwarding, load-use stall, flush and async reset.
module tb_id_ex_operand_stage;
    import rv32_pkg::*;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    id_ex_operand_stage_if #(.XLEN(32), .STALL_CNT_W(16)) bus ();

    id_ex_operand_stage #(.XLEN(32), .STALL_CNT_W(16)) dut (
        .CLK    (clk),
        .RESETN (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_fwd();
        bus.flush           = 1'b0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_rd        = 5'd0;
        bus.exmem_result    = 32'd0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_rd        = 5'd0;
        bus.memwb_result    = 32'd0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] rs1d, input logic [31:0] rs2d,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] sel,
                            input logic alu_src, input logic pc_src, input logic rw,
                            input logic mr, input logic mw, input logic [2:0] f3);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_rs1_data  = rs1d;
        bus.id_rs2_data  = rs2d;
        bus.id_imm       = imm;
        bus.id_pc        = pc;
        bus.id_alu_sel   = sel;
        bus.id_alu_src   = alu_src;
        bus.id_pc_src    = pc_src;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
        bus.id_funct3    = f3;
        clear_fwd();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lw x4, 8(x1)
    task automatic drive_lw_x4();
        drive_id(1, 5'd1, 5'd0, 5'd4, 32'h200, 32'h0, 32'd8, 32'h2000, ALU_ADD, 1, 0, 1, 1, 0, 3'd2);
    endtask

    // add x5, x4, x6 with stale x4 data
    task automatic drive_add_dep();
        drive_id(1, 5'd4, 5'd6, 5'd5, 32'h0, 32'h30, 32'h0, 32'h2004, ALU_ADD, 0, 0, 1, 0, 0, 3'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_data1", bus.ex_data1, 32'd0);
        chk("rst_cnt",   {16'd0, bus.stall_cnt}, 32'd0);
        resetn = 1'b1;

        // add x2, x1, x1 with EX/MEM forwarding of x1
        drive_id(1, 5'd1, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'h40, ALU_ADD, 0, 0, 1, 0, 0, 3'd0);
        tick();
        bus.id_valid = 1'b0;
        #1;
        chk("nofwd_d1", bus.ex_data1, 32'd5);
        chk("nofwd_d2", bus.ex_data2, 32'd7);
        bus.exmem_reg_write = 1'b1;
        bus.exmem_rd        = 5'd1;
        bus.exmem_result    = 32'd12;
        #1;
        chk("exmem_d1",  bus.ex_data1, 32'd12);
        chk("exmem_d2",  bus.ex_data2, 32'd12);
        chk("exmem_st",  bus.ex_store_data, 32'd12);
        chk("exmem_sel", {27'd0, bus.ex_alu_sel}, 32'd0);
        chk("exmem_rd",  {27'd0, bus.ex_rd}, 32'd2);
        chk("exmem_vld", {31'd0, bus.ex_valid}, 32'd1);

        // priority: EX/MEM over MEM/WB, immediate on DATA2
        drive_id(1, 5'd3, 5'd4, 5'd7, 32'h100, 32'h200, 32'h55, 32'h44, ALU_SUB, 1, 0, 1, 0, 0, 3'd2);
        tick();
        bus.id_valid        = 1'b0;
        bus.exmem_reg_write = 1'b1;
        bus.exmem_rd        = 5'd3;
        bus.exmem_result    = 32'h11;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_rd        = 5'd3;
        bus.memwb_result    = 32'h22;
        #1;
        chk("prio_d1",  bus.ex_data1, 32'h11);
        chk("prio_d2",  bus.ex_data2, 32'h55);
        chk("prio_st",  bus.ex_store_data, 32'h200);
        chk("prio_sel", {27'd0, bus.ex_alu_sel}, {27'd0, ALU_SUB});
        chk("prio_f3",  {29'd0, bus.ex_funct3}, 32'd2);
        bus.exmem_reg_write = 1'b0;
        #1;
        chk("memwb_d1", bus.ex_data1, 32'h22);
        bus.memwb_rd = 5'd4;
        #1;
        chk("memwb_st", bus.ex_store_data, 32'h22);
        chk("memwb_d2", bus.ex_data2, 32'h55);
        chk("memwb_d1r", bus.ex_data1, 32'h100);

        // x0 never forwarded
        drive_id(1, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 32'd0, ALU_ADD, 0, 0, 1, 0, 0, 3'd0);
        tick();
        bus.id_valid        = 1'b0;
        bus.exmem_reg_write = 1'b1;
        bus.exmem_rd        = 5'd0;
        bus.exmem_result    = 32'hDEAD;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_rd        = 5'd0;
        bus.memwb_result    = 32'hBEEF;
        #1;
        chk("x0_d1", bus.ex_data1, 32'd0);
        chk("x0_st", bus.ex_store_data, 32'd0);

        // AUIPC-style: DATA1 = PC
        drive_id(1, 5'd1, 5'd2, 5'd3, 32'h9, 32'hA, 32'h4, 32'h1000, ALU_ADD, 1, 1, 1, 0, 0, 3'd0);
        tick();
        chk("pcsrc_d1", bus.ex_data1, 32'h1000);
        chk("pcsrc_d2", bus.ex_data2, 32'h4);
        chk("pcsrc_pc", bus.ex_pc, 32'h1000);

        // load-use: one stall cycle then MEM/WB forwarding
        drive_lw_x4();
        tick();
        chk("lw_mr", {31'd0, bus.ex_mem_read}, 32'd1);
        drive_add_dep();
        #1;
        chk("lu_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        chk("lu_bub_vld", {31'd0, bus.ex_valid}, 32'd0);
        chk("lu_bub_rw",  {31'd0, bus.ex_reg_write}, 32'd0);
        chk("lu_bub_rd",  {27'd0, bus.ex_rd}, 32'd0);
        chk("lu_cnt1",    {16'd0, bus.stall_cnt}, 32'd1);
        chk("lu_unstall", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.memwb_reg_write = 1'b1;
        bus.memwb_rd        = 5'd4;
        bus.memwb_result    = 32'h777;
        #1;
        chk("lu_d1",  bus.ex_data1, 32'h777);
        chk("lu_d2",  bus.ex_data2, 32'h30);
        chk("lu_vld", {31'd0, bus.ex_valid}, 32'd1);
        chk("lu_rd",  {27'd0, bus.ex_rd}, 32'd5);
        chk("lu_cnt", {16'd0, bus.stall_cnt}, 32'd1);

        // flush beats stall
        drive_lw_x4();
        tick();
        drive_add_dep();
        bus.flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        chk("fl_vld", {31'd0, bus.ex_valid}, 32'd0);
        chk("fl_cnt", {16'd0, bus.stall_cnt}, 32'd1);
        bus.flush = 1'b0;

        // rs2-only match still stalls
        drive_lw_x4();
        tick();
        drive_id(1, 5'd0, 5'd4, 5'd5, 32'd0, 32'd0, 32'd0, 32'd0, ALU_ADD, 1, 0, 1, 0, 0, 3'd0);
        #1;
        chk("rs2_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        chk("rs2_cnt", {16'd0, bus.stall_cnt}, 32'd2);

        for (int i = 0; i < 3; i++) begin
            drive_lw_x4();
            tick();
            drive_add_dep();
            tick();
        end
        drive_id(1, 5'd6, 5'd7, 5'd8, 32'h1, 32'h2, 32'h0, 32'h3000, ALU_OR, 0, 0, 1, 0, 0, 3'd0);
        tick();
        chk("pre_rst_vld", {31'd0, bus.ex_valid}, 32'd1);
        chk("pre_rst_cnt", {16'd0, bus.stall_cnt}, 32'd5);

        // asynchronous reset between clock edges
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_vld",   {31'd0, bus.ex_valid}, 32'd0);
        chk("arst_cnt",   {16'd0, bus.stall_cnt}, 32'd0);
        chk("arst_stall", {31'd0, bus.stall}, 32'd0);
        chk("arst_pc",    bus.ex_pc, 32'd0);
        chk("arst_rw",    {31'd0, bus.ex_reg_write}, 32'd0);
        chk("arst_d1",    bus.ex_data1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
